// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
// Bundles the operand/control inputs and the registered result outputs of
// alu_exec_unit. Clock and reset stay plain ports on the unit itself.
//
//   master : the producer side (decode stage / testbench); drives operands
//            and controls, observes results.
//   slave  : the execution unit; reads operands and controls, drives results.
//
// Signals
//   in_valid            operands/controls valid this cycle
//   aluop[1:0]          main-control ALU op
//   funct[3:0]          instruction bits [3:0]
//   shamt[4:0]          shift amount, instruction bits [10:6]
//   a, b                operands (rs data, rt data / immediate)
//   pc, offset          program counter, sign-extended word branch offset
//   out_valid           registered in_valid
//   result, zero, neg   ALU result and its flags
//   gout[2:0]           decoded ALU operation code
//   link_rt, reg31_rt   R-type link / write-to-r31 requests
//   pc_plus4, br_target sequential PC and branch target
// ---------------------------------------------------------------------------
interface alu_exec_unit_if;
  logic        in_valid;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [31:0] offset;

  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        neg;
  logic [2:0]  gout;
  logic        link_rt;
  logic        reg31_rt;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;

  modport master (
    output in_valid, aluop, funct, shamt, a, b, pc, offset,
    input  out_valid, result, zero, neg, gout, link_rt, reg31_rt,
           pc_plus4, br_target
  );

  modport slave (
    input  in_valid, aluop, funct, shamt, a, b, pc, offset,
    output out_valid, result, zero, neg, gout, link_rt, reg31_rt,
           pc_plus4, br_target
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Single-cycle-latency execute stage: decodes aluop/funct into a 3-bit ALU
// operation code, computes the ALU result and flags, and forms the
// sequential PC and branch target. All outputs are registered; when
// in_valid is low only out_valid drops and every other output holds.
//
// Parameters
//   PC_INC   constant added to pc to form pc_plus4 (default 4)
//
// Ports
//   clk      single clock, rising edge
//   reset    synchronous, active-high; clears all outputs, zero set to 1
//   bus      alu_exec_unit_if.slave (operands in, results out)
//
// Build option
//   ALU_SHIFT_EN  when defined, funct 1000 (SLL) and 1011 (SRL) drive a
//                 shifter on b by shamt; when undefined those functs decode
//                 as ADD and no shifter exists.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic            clk,
  input  logic            reset,
  alu_exec_unit_if.slave  bus
);

  localparam logic [2:0] G_AND = 3'b000;
  localparam logic [2:0] G_OR  = 3'b001;
  localparam logic [2:0] G_ADD = 3'b010;
  localparam logic [2:0] G_SLL = 3'b011;
  localparam logic [2:0] G_SRL = 3'b100;
  localparam logic [2:0] G_NOR = 3'b101;
  localparam logic [2:0] G_SUB = 3'b110;
  localparam logic [2:0] G_SLT = 3'b111;

  logic        out_valid_q;
  logic [31:0] result_d,    result_q;
  logic        zero_d,      zero_q;
  logic        neg_d,       neg_q;
  logic [2:0]  gout_d,      gout_q;
  logic        link_rt_d,   link_rt_q;
  logic        reg31_rt_d,  reg31_rt_q;
  logic [31:0] pc_plus4_d,  pc_plus4_q;
  logic [31:0] br_target_d, br_target_q;

  // offset[31:30] fall off the word-to-byte shift; shamt is only consumed
  // by the shifter build.
`ifdef ALU_SHIFT_EN
  logic unused_bits;
  assign unused_bits = ^bus.offset[31:30];
`else
  logic unused_bits;
  assign unused_bits = ^{bus.offset[31:30], bus.shamt};
`endif

  // Operation decode.
  always_comb begin
    gout_d     = G_ADD;
    link_rt_d  = 1'b0;
    reg31_rt_d = 1'b0;
    case (bus.aluop)
      2'b00: gout_d = G_ADD;
      2'b01: gout_d = G_SUB;
      2'b11: gout_d = G_OR;
      default: begin
        case (bus.funct)
          4'b0000: gout_d = G_ADD;
          4'b0010: gout_d = G_SUB;
          4'b0100: gout_d = G_AND;
          4'b0101: gout_d = G_OR;
          4'b0111: gout_d = G_NOR;
          4'b1010: gout_d = G_SLT;
`ifdef ALU_SHIFT_EN
          4'b1000: gout_d = G_SLL;
          4'b1011: gout_d = G_SRL;
`endif
          4'b1001: begin
            // Jump-and-link style R-type: the ALU still adds, the
            // writeback stage uses the two request bits.
            gout_d     = G_ADD;
            link_rt_d  = 1'b1;
            reg31_rt_d = 1'b1;
          end
          default: gout_d = G_ADD;
        endcase
      end
    endcase
  end

  // Datapath.
  always_comb begin
    result_d = bus.a + bus.b;
    case (gout_d)
      G_AND: result_d = bus.a & bus.b;
      G_OR:  result_d = bus.a | bus.b;
      G_ADD: result_d = bus.a + bus.b;
      G_SUB: result_d = bus.a - bus.b;
      G_NOR: result_d = ~(bus.a | bus.b);
      G_SLT: result_d = {31'd0, ($signed(bus.a) < $signed(bus.b))};
`ifdef ALU_SHIFT_EN
      G_SLL: result_d = bus.b << bus.shamt;
      G_SRL: result_d = bus.b >> bus.shamt;
`endif
      default: result_d = bus.a + bus.b;
    endcase
    zero_d      = (result_d == 32'd0);
    neg_d       = result_d[31];
    pc_plus4_d  = bus.pc + PC_INC;
    br_target_d = pc_plus4_d + {bus.offset[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      gout_q      <= 3'd0;
      link_rt_q   <= 1'b0;
      reg31_rt_q  <= 1'b0;
      pc_plus4_q  <= 32'd0;
      br_target_q <= 32'd0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q    <= result_d;
        zero_q      <= zero_d;
        neg_q       <= neg_d;
        gout_q      <= gout_d;
        link_rt_q   <= link_rt_d;
        reg31_rt_q  <= reg31_rt_d;
        pc_plus4_q  <= pc_plus4_d;
        br_target_q <= br_target_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.gout      = gout_q;
  assign bus.link_rt   = link_rt_q;
  assign bus.reg31_rt  = reg31_rt_q;
  assign bus.pc_plus4  = pc_plus4_q;
  assign bus.br_target = br_target_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed, table-driven bench for alu_exec_unit (PC_INC = 4). Vectors are
// applied back-to-back, one per cycle, and all outputs are compared one
// cycle later. Hand-written sequences cover reset with a pending operation,
// output hold while in_valid is low, and a mid-run reset.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  typedef struct {
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] offset;
    logic [31:0] exp_result;
    logic [2:0]  exp_gout;
    logic        exp_link;
    logic [31:0] exp_pc4;
    logic [31:0] exp_br;
  } vec_t;

  localparam int NVEC = 16;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_failed;
  vec_t vecs [NVEC];

  alu_exec_unit_if bus ();

  alu_exec_unit #(.PC_INC(32'd4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " result"},    bus.result,             32'd0);
    check({tag, " zero"},      {31'd0, bus.zero},      32'd1);
    check({tag, " neg"},       {31'd0, bus.neg},       32'd0);
    check({tag, " gout"},      {29'd0, bus.gout},      32'd0);
    check({tag, " link_rt"},   {31'd0, bus.link_rt},   32'd0);
    check({tag, " reg31_rt"},  {31'd0, bus.reg31_rt},  32'd0);
    check({tag, " pc_plus4"},  bus.pc_plus4,           32'd0);
    check({tag, " br_target"}, bus.br_target,          32'd0);
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.in_valid = valid;
    bus.aluop    = v.aluop;
    bus.funct    = v.funct;
    bus.shamt    = v.shamt;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.pc       = v.pc;
    bus.offset   = v.offset;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("vec%0d", i);
    check({t, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({t, " result"},    bus.result,             v.exp_result);
    check({t, " gout"},      {29'd0, bus.gout},      {29'd0, v.exp_gout});
    check({t, " zero"},      {31'd0, bus.zero},      {31'd0, (v.exp_result == 32'd0)});
    check({t, " neg"},       {31'd0, bus.neg},       {31'd0, v.exp_result[31]});
    check({t, " link_rt"},   {31'd0, bus.link_rt},   {31'd0, v.exp_link});
    check({t, " reg31_rt"},  {31'd0, bus.reg31_rt},  {31'd0, v.exp_link});
    check({t, " pc_plus4"},  bus.pc_plus4,           v.exp_pc4);
    check({t, " br_target"}, bus.br_target,          v.exp_br);
  endtask

  initial begin
    vec_t v;
    n_tests  = 0;
    n_failed = 0;

    //        aluop  funct    shamt a             b             pc            offset        result        gout    lnk  pc4           br
    vecs[0]  = '{2'b10, 4'b0000, 5'd0,  32'd5,        32'd7,        32'h100,      32'd1,        32'd12,       3'b010, 1'b0, 32'h104,      32'h108};
    vecs[1]  = '{2'b01, 4'b0000, 5'd0,  32'd3,        32'd3,        32'h100,      32'd1,        32'd0,        3'b110, 1'b0, 32'h104,      32'h108};
    vecs[2]  = '{2'b01, 4'b0000, 5'd0,  32'd0,        32'd1,        32'h100,      32'd1,        32'hFFFFFFFF, 3'b110, 1'b0, 32'h104,      32'h108};
    vecs[3]  = '{2'b10, 4'b1010, 5'd0,  32'hFFFFFFFF, 32'd1,        32'h100,      32'd1,        32'd1,        3'b111, 1'b0, 32'h104,      32'h108};
    vecs[4]  = '{2'b10, 4'b1010, 5'd0,  32'd1,        32'hFFFFFFFF, 32'h100,      32'd1,        32'd0,        3'b111, 1'b0, 32'h104,      32'h108};
    vecs[5]  = '{2'b10, 4'b1001, 5'd0,  32'd0,        32'd0,        32'h10,       32'hFFFFFFFF, 32'd0,        3'b010, 1'b1, 32'h14,       32'h10};
    vecs[6]  = '{2'b00, 4'b0000, 5'd0,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFC, 32'd0,        32'd0,        3'b010, 1'b0, 32'h0,        32'h0};
    vecs[7]  = '{2'b11, 4'b0000, 5'd0,  32'hF0,       32'h0F,       32'h100,      32'd1,        32'hFF,       3'b001, 1'b0, 32'h104,      32'h108};
    vecs[8]  = '{2'b10, 4'b0100, 5'd0,  32'hFF00FF00, 32'h0F0F0F0F, 32'h100,      32'd1,        32'h0F000F00, 3'b000, 1'b0, 32'h104,      32'h108};
    vecs[9]  = '{2'b10, 4'b0101, 5'd0,  32'hFF00FF00, 32'h0F0F0F0F, 32'h100,      32'd1,        32'hFF0FFF0F, 3'b001, 1'b0, 32'h104,      32'h108};
    vecs[10] = '{2'b10, 4'b0111, 5'd0,  32'hFF00FF00, 32'h0F0F0F0F, 32'h100,      32'd1,        32'h00F000F0, 3'b101, 1'b0, 32'h104,      32'h108};
    vecs[11] = '{2'b10, 4'b0010, 5'd0,  32'd16,       32'd32,       32'h100,      32'd1,        32'hFFFFFFF0, 3'b110, 1'b0, 32'h104,      32'h108};
    vecs[12] = '{2'b10, 4'b1111, 5'd0,  32'd1,        32'd2,        32'h100,      32'd1,        32'd3,        3'b010, 1'b0, 32'h104,      32'h108};
`ifdef ALU_SHIFT_EN
    vecs[13] = '{2'b10, 4'b1000, 5'd31, 32'd2,        32'd1,        32'h100,      32'd1,        32'h80000000, 3'b011, 1'b0, 32'h104,      32'h108};
    vecs[14] = '{2'b10, 4'b1011, 5'd4,  32'd1,        32'h80000000, 32'h100,      32'd1,        32'h08000000, 3'b100, 1'b0, 32'h104,      32'h108};
`else
    vecs[13] = '{2'b10, 4'b1000, 5'd31, 32'd2,        32'd1,        32'h100,      32'd1,        32'd3,        3'b010, 1'b0, 32'h104,      32'h108};
    vecs[14] = '{2'b10, 4'b1011, 5'd4,  32'd1,        32'h80000000, 32'h100,      32'd1,        32'h80000001, 3'b010, 1'b0, 32'h104,      32'h108};
`endif
    // funct 1001 outside aluop=10 must not raise the link requests.
    vecs[15] = '{2'b00, 4'b1001, 5'd0,  32'd1,        32'd1,        32'h200,      32'hFFFFFFFE, 32'd2,        3'b010, 1'b0, 32'h204,      32'h1FC};

    // Reset with an operation presented: it must be discarded.
    reset = 1'b1;
    v = '{2'b00, 4'b0000, 5'd0, 32'd1, 32'd1, 32'h100, 32'd1,
          32'd0, 3'b000, 1'b0, 32'd0, 32'd0};
    drive(v, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_cleared("reset");
    $display("[TB] reset with in_valid=1: outputs cleared");

    // Back-to-back vectors; the first one is the first operation after reset.
    reset = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i], 1'b1);
      @(posedge clk); #1;
      check_vec(i, vecs[i]);
      $display("[TB] vec%0d aluop=%b funct=%b a=%h b=%h -> result=%h gout=%b",
               i, vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b,
               bus.result, bus.gout);
    end

    // in_valid low: out_valid drops, everything else holds vecs[15] results
    // even though the inputs now describe a different operation.
    v = '{2'b10, 4'b1001, 5'd0, 32'h55, 32'h66, 32'h300, 32'd5,
          32'd0, 3'b000, 1'b0, 32'd0, 32'd0};
    drive(v, 1'b0);
    @(posedge clk); #1;
    check("hold out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("hold result",    bus.result,             vecs[15].exp_result);
    check("hold gout",      {29'd0, bus.gout},      {29'd0, vecs[15].exp_gout});
    check("hold link_rt",   {31'd0, bus.link_rt},   32'd0);
    check("hold pc_plus4",  bus.pc_plus4,           vecs[15].exp_pc4);
    check("hold br_target", bus.br_target,          vecs[15].exp_br);
    $display("[TB] idle cycle: out_valid=%b result=%h (held)",
             bus.out_valid, bus.result);

    // Valid again after the idle cycle.
    drive(vecs[5], 1'b1);
    @(posedge clk); #1;
    check_vec(100, vecs[5]);
    $display("[TB] resume link op: link_rt=%b br_target=%h",
             bus.link_rt, bus.br_target);

    // Mid-run reset overrides a valid operation.
    reset = 1'b1;
    drive(vecs[2], 1'b1);
    @(posedge clk); #1;
    check_cleared("midreset");
    $display("[TB] mid-run reset with in_valid=1: outputs cleared");

    // First operation after the reset completes normally.
    reset = 1'b0;
    drive(vecs[2], 1'b1);
    @(posedge clk); #1;
    check_vec(101, vecs[2]);
    $display("[TB] post-reset sub: result=%h neg=%b", bus.result, bus.neg);

    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
